// File: rtl/load_data_if.sv
// System-bus and arbiter signals between the line fill engine (master) and the
// bus/arbiter side (slave).
interface load_data_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      abtr_grant;
    logic                      abtr_reqcyc;
    logic                      bus_busy;
    logic                      main_bus_reqcyc;
    logic                      main_bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] main_bus_req;
    logic [BUS_TAG_WIDTH-1:0]  main_bus_reqtag;
    logic                      main_bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] main_bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  main_bus_resptag;
    logic                      main_bus_respack;

    modport master (
        input  abtr_grant, main_bus_reqack, main_bus_respcyc, main_bus_resp, main_bus_resptag,
        output abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req, main_bus_reqtag,
               main_bus_respack
    );

    modport slave (
        output abtr_grant, main_bus_reqack, main_bus_respcyc, main_bus_resp, main_bus_resptag,
        input  abtr_reqcyc, bus_busy, main_bus_reqcyc, main_bus_req, main_bus_reqtag,
               main_bus_respack
    );
endinterface

// File: rtl/load_data.sv
// Cache-line fill engine: wins the arbiter, issues one line read, gathers
// LINE_BEATS response beats into a line and presents it with ready.
module load_data #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [BUS_DATA_WIDTH-1:0]            addr,
    load_data_if.master                          bus,
    output logic                                 ready,
    output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] data
);
    localparam int IDXW = $clog2(LINE_BEATS);
    localparam int CNTW = IDXW + 1;
    localparam int OFFW = $clog2(BUS_DATA_WIDTH * LINE_BEATS / 8);
    localparam logic [BUS_TAG_WIDTH-1:0] SYSBUS_READ   = BUS_TAG_WIDTH'(1);
    localparam logic [BUS_TAG_WIDTH-1:0] SYSBUS_MEMORY = BUS_TAG_WIDTH'(1);
    localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG      = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);

    typedef enum logic [2:0] {IDLE, ARB, ADDRREQ, RESP, READY} state_t;

    state_t                                    state_q, state_d;
    logic [CNTW-1:0]                           cnt_q;
    logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0] line_q;
    logic [BUS_DATA_WIDTH-1:0]                 line_addr_q, req_q;
    logic [BUS_TAG_WIDTH-1:0]                  tag_q;
    logic                                      abtr_q, busy_q, reqcyc_q, ready_q;
    logic                                      beat;
    logic                                      unused_ok;

    assign beat      = (state_q == RESP) && bus.main_bus_respcyc;
    assign unused_ok = ^{bus.main_bus_resptag, addr[OFFW-1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (enable) state_d = ARB;
            ARB:         if (bus.abtr_grant) state_d = ADDRREQ;
            ADDRREQ:     if (bus.main_bus_reqack) state_d = RESP;
            RESP:        if (beat && cnt_q == CNTW'(LINE_BEATS - 1)) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            line_addr_q <= '0;
            req_q       <= '0;
            tag_q       <= '0;
            abtr_q      <= 1'b0;
            busy_q      <= 1'b0;
            reqcyc_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            abtr_q   <= state_d inside {ARB, ADDRREQ, RESP};
            busy_q   <= state_d inside {ADDRREQ, RESP};
            reqcyc_q <= (state_d == ADDRREQ);
            req_q    <= (state_d == ADDRREQ) ? line_addr_q : '0;
            tag_q    <= (state_d == ADDRREQ) ? READ_TAG : '0;
            ready_q  <= (state_d == READY);
            if ((state_q == IDLE || state_q == READY) && enable)
                line_addr_q <= {addr[BUS_DATA_WIDTH-1:OFFW], OFFW'(0)};
            // Counter restarts while the request is pending, so RESP always begins at beat 0.
            if (state_q == ADDRREQ) begin
                cnt_q <= '0;
            end else if (beat) begin
                line_q[cnt_q[IDXW-1:0]] <= bus.main_bus_resp;
                cnt_q                   <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.abtr_reqcyc      = abtr_q;
    assign bus.bus_busy         = busy_q;
    assign bus.main_bus_reqcyc  = reqcyc_q;
    assign bus.main_bus_req     = req_q;
    assign bus.main_bus_reqtag  = tag_q;
    assign bus.main_bus_respack = beat;
    assign ready                = ready_q;
    assign data                 = line_q;
endmodule

// File: tb/tb_load_data.sv
// Directed bench for the line fill engine: request phase, beat capture,
// gaps, mid-transfer reset and back-to-back restart from READY.
module tb_load_data;
    localparam int W = 64;
    localparam int T = 13;
    localparam int B = 8;
    localparam logic [T-1:0] READ_TAG = 13'h1100;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [W-1:0]   addr;
    logic           ready;
    logic [W*B-1:0] data;
    int             nvec = 0;
    int             nerr = 0;

    load_data_if #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T)) bif ();

    load_data #(.BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .LINE_BEATS(B)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr),
        .bus(bif.master), .ready(ready), .data(data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W*B-1:0] mkline(input logic [W-1:0] base);
        logic [W*B-1:0] l;
        for (int i = 0; i < B; i++) l[W*i +: W] = base + W'(i);
        return l;
    endfunction

    task automatic idle_inputs();
        enable               = 1'b0;
        bif.abtr_grant       = 1'b0;
        bif.main_bus_reqack  = 1'b0;
        bif.main_bus_respcyc = 1'b0;
        bif.main_bus_resp    = '0;
        bif.main_bus_resptag = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            enable               = 1'($urandom);
            addr                 = {$urandom, $urandom};
            bif.abtr_grant       = 1'($urandom);
            bif.main_bus_reqack  = 1'($urandom);
            bif.main_bus_respcyc = 1'($urandom);
            bif.main_bus_resp    = {$urandom, $urandom};
            bif.main_bus_resptag = T'($urandom);
            tick();
        end
        bif.main_bus_respcyc = 1'b0;
        #1;
        nvec++;
        if ({bif.abtr_reqcyc, bif.bus_busy, bif.main_bus_reqcyc, bif.main_bus_respack, ready} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b want 00000", {bif.abtr_reqcyc, bif.bus_busy,
                     bif.main_bus_reqcyc, bif.main_bus_respack, ready});
        end
        nvec++;
        if (bif.main_bus_req !== '0 || bif.main_bus_reqtag !== '0) begin
            nerr++;
            $display("FAIL reset_req: got req %h tag %h want 0/0", bif.main_bus_req, bif.main_bus_reqtag);
        end
        nvec++;
        if (data !== '0) begin nerr++; $display("FAIL reset_data: got %h want 0", data); end
        idle_inputs();
        reset = 1'b1;
        tick();
        nvec++;
        if (bif.abtr_reqcyc !== 1'b0) begin nerr++; $display("FAIL reset_idle: abtr_reqcyc %b want 0", bif.abtr_reqcyc); end
    endtask

    // Drives enable, grant after gdly cycles, reqack after adly cycles; optional respcyc in the reqack cycle.
    task automatic test_request(input logic [W-1:0] a, input int gdly, input int adly, input bit early, input bit hold);
        logic [W-1:0] exp_req;
        exp_req = {a[W-1:6], 6'b0};
        addr    = a;
        enable  = 1'b1;
        tick();
        enable  = hold;
        nvec++;
        if (bif.abtr_reqcyc !== 1'b1 || bif.bus_busy !== 1'b0 || ready !== 1'b0 || bif.main_bus_reqcyc !== 1'b0) begin
            nerr++;
            $display("FAIL arb_entry: abtr %b busy %b ready %b reqcyc %b want 1 0 0 0",
                     bif.abtr_reqcyc, bif.bus_busy, ready, bif.main_bus_reqcyc);
        end
        for (int c = 0; c < gdly; c++) begin
            tick();
            nvec++;
            if (bif.abtr_reqcyc !== 1'b1 || bif.main_bus_reqcyc !== 1'b0) begin
                nerr++;
                $display("FAIL arb_wait: abtr %b reqcyc %b want 1 0", bif.abtr_reqcyc, bif.main_bus_reqcyc);
            end
        end
        bif.abtr_grant = 1'b1;
        tick();
        bif.abtr_grant = 1'b0;
        enable         = 1'b0;
        for (int c = 0; c <= adly; c++) begin
            if (c == adly) begin
                bif.main_bus_reqack = 1'b1;
                if (early) begin
                    bif.main_bus_respcyc = 1'b1;
                    bif.main_bus_resp    = 64'hDEAD_BEEF;
                end
                #1;
                nvec++;
                if (bif.main_bus_respack !== 1'b0) begin
                    nerr++;
                    $display("FAIL reqack_respack: got %b want 0", bif.main_bus_respack);
                end
            end
            nvec++;
            if (bif.main_bus_reqcyc !== 1'b1 || bif.main_bus_req !== exp_req ||
                bif.main_bus_reqtag !== READ_TAG || bif.bus_busy !== 1'b1) begin
                nerr++;
                $display("FAIL addrreq: reqcyc %b req %h tag %h busy %b want 1 %h %h 1",
                         bif.main_bus_reqcyc, bif.main_bus_req, bif.main_bus_reqtag, bif.bus_busy,
                         exp_req, READ_TAG);
            end
            tick();
        end
        bif.main_bus_reqack  = 1'b0;
        bif.main_bus_respcyc = 1'b0;
        nvec++;
        if (bif.main_bus_reqcyc !== 1'b0 || bif.main_bus_reqtag !== '0 ||
            bif.bus_busy !== 1'b1 || bif.abtr_reqcyc !== 1'b1) begin
            nerr++;
            $display("FAIL resp_entry: reqcyc %b tag %h busy %b abtr %b want 0 0 1 1",
                     bif.main_bus_reqcyc, bif.main_bus_reqtag, bif.bus_busy, bif.abtr_reqcyc);
        end
    endtask

    // Sends beats first..last with data base+i; gap_at inserts two idle cycles before that beat.
    task automatic test_beats(input logic [W-1:0] base, input int gap_at, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 2; g++) begin
                    bif.main_bus_respcyc = 1'b0;
                    tick();
                    nvec++;
                    if (bif.main_bus_respack !== 1'b0 || ready !== 1'b0 || bif.bus_busy !== 1'b1) begin
                        nerr++;
                        $display("FAIL gap: respack %b ready %b busy %b want 0 0 1",
                                 bif.main_bus_respack, ready, bif.bus_busy);
                    end
                end
            end
            bif.main_bus_respcyc = 1'b1;
            bif.main_bus_resp    = base + W'(i);
            bif.main_bus_resptag = T'($urandom);
            #1;
            nvec++;
            if (bif.main_bus_respack !== 1'b1) begin
                nerr++;
                $display("FAIL beat_respack: beat %0d got %b want 1", i, bif.main_bus_respack);
            end
            tick();
            bif.main_bus_respcyc = 1'b0;
            nvec++;
            if (ready !== (i == B - 1)) begin
                nerr++;
                $display("FAIL beat_ready: beat %0d got %b want %b", i, ready, (i == B - 1));
            end
        end
    endtask

    task automatic check_ready_line(input logic [W*B-1:0] exp, input string nm);
        nvec++;
        if (ready !== 1'b1 || bif.bus_busy !== 1'b0 || bif.abtr_reqcyc !== 1'b0 || data !== exp) begin
            nerr++;
            $display("FAIL %s: ready %b busy %b abtr %b data %h want 1 0 0 %h",
                     nm, ready, bif.bus_busy, bif.abtr_reqcyc, data, exp);
        end
    endtask

    task automatic test_contiguous();
        test_request(64'h0000_0000_1234_5678, 2, 3, 1'b0, 1'b0);
        test_beats(64'h1000, -1, 0, B - 1);
        check_ready_line(mkline(64'h1000), "line_contig");
        tick();
        check_ready_line(mkline(64'h1000), "ready_hold");
    endtask

    task automatic test_gaps();
        test_request(64'h0000_0000_1234_5678, 0, 0, 1'b1, 1'b0);
        test_beats(64'h1000, 4, 0, B - 1);
        check_ready_line(mkline(64'h1000), "line_gaps");
    endtask

    task automatic test_midreset();
        test_request(64'h0000_0000_0BAD_0000, 1, 1, 1'b0, 1'b0);
        test_beats(64'h2000, -1, 0, 4);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        nvec++;
        if (ready !== 1'b0 || data !== '0 || bif.abtr_reqcyc !== 1'b0 || bif.bus_busy !== 1'b0) begin
            nerr++;
            $display("FAIL midreset: ready %b data %h abtr %b busy %b want 0 0 0 0",
                     ready, data, bif.abtr_reqcyc, bif.bus_busy);
        end
        bif.main_bus_respcyc = 1'b1;
        bif.main_bus_resp    = 64'hBAD;
        #1;
        nvec++;
        if (bif.main_bus_respack !== 1'b0) begin nerr++; $display("FAIL idle_respack: got %b want 0", bif.main_bus_respack); end
        tick();
        bif.main_bus_respcyc = 1'b0;
        nvec++;
        if (data !== '0) begin nerr++; $display("FAIL idle_data: got %h want 0", data); end
        test_request(64'h40, 0, 0, 1'b0, 1'b0);
        test_beats(64'h3000, -1, 0, B - 1);
        check_ready_line(mkline(64'h3000), "line_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W*B-1:0] exp;
        bif.main_bus_respcyc = 1'b1;
        bif.main_bus_resp    = 64'hFFFF;
        #1;
        nvec++;
        if (bif.main_bus_respack !== 1'b0) begin nerr++; $display("FAIL ready_respack: got %b want 0", bif.main_bus_respack); end
        tick();
        bif.main_bus_respcyc = 1'b0;
        check_ready_line(mkline(64'h3000), "ready_ignore_resp");
        test_request(64'h0000_0000_0000_0080, 1, 0, 1'b0, 1'b1);
        exp = mkline(64'h3000);
        nvec++;
        if (data !== exp) begin nerr++; $display("FAIL old_data_kept: got %h want %h", data, exp); end
        test_beats(64'h4000, -1, 0, 0);
        exp[W-1:0] = 64'h4000;
        nvec++;
        if (data !== exp) begin nerr++; $display("FAIL partial_overwrite: got %h want %h", data, exp); end
        test_beats(64'h4000, -1, 1, B - 1);
        check_ready_line(mkline(64'h4000), "line_b2b");
    endtask

    initial begin
        idle_inputs();
        addr  = '0;
        reset = 1'b0;
        test_reset();
        test_contiguous();
        test_gaps();
        test_midreset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/load_data.md
Name: load_data

Overview:
Cache-line fill engine. It is the read counterpart of the line-store block on the system bus. On `enable` it wins the arbiter, issues a single read request for the 64-byte line containing `addr`, and collects 8 response beats of 64 bits into a 512-bit line. It then presents the line with `ready` high. It sits between the cache miss logic and the main system bus.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus request/response data.
- BUS_TAG_WIDTH, 13, width of request/response tags.
- LINE_BEATS, 8, response beats per line; the line is BUS_DATA_WIDTH*LINE_BEATS bits.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-low reset; reset==0 resets the block.
- enable  in  1  start request; sampled in IDLE and READY.
- addr  in  BUS_DATA_WIDTH  byte address of the line to fetch.
- abtr_grant  in  1  arbiter grant.
- abtr_reqcyc  out  1  arbiter request.
- bus_busy  out  1  block owns the bus.
- main_bus_reqcyc  out  1  request valid.
- main_bus_reqack  in  1  request accepted.
- main_bus_req  out  BUS_DATA_WIDTH  request address.
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_respcyc  in  1  response beat valid.
- main_bus_resp  in  BUS_DATA_WIDTH  response beat data.
- main_bus_resptag  in  BUS_TAG_WIDTH  response tag; not checked.
- main_bus_respack  out  1  response beat acknowledge.
- ready  out  1  line valid.
- data  out  BUS_DATA_WIDTH*LINE_BEATS  assembled line.

Behaviour:
- States: IDLE, ARB, ADDRREQ, RESP, READY. The state register, 4-bit beat counter and data register are all updated on posedge clk.
- Reset (reset==0 at posedge):
  - state=IDLE, counter=0, data=0.
  - All control outputs are 0; main_bus_req=0; main_bus_reqtag=0.
  - Reset aborts any transfer in progress; the partial line is discarded.
- Control outputs are decoded from the current state only. Exception: respack, see RESP.
- IDLE: all outputs 0. enable=1 → ARB.
- ARB:
  - abtr_reqcyc=1; bus_busy=0.
  - abtr_grant=1 → ADDRREQ; otherwise stay in ARB.
- ADDRREQ:
  - abtr_reqcyc=1, bus_busy=1, main_bus_reqcyc=1.
  - main_bus_req = {addr[63:6], 6'b0}.
  - main_bus_reqtag = `SYSBUS_READ<<12 | `SYSBUS_MEMORY<<8.
  - Request is held stable until main_bus_reqack=1; that cycle → RESP with counter=0.
- RESP:
  - abtr_reqcyc=1, bus_busy=1, main_bus_reqcyc=0, reqtag=0.
  - main_bus_respack = main_bus_respcyc (combinational, same cycle).
  - Each cycle with respcyc=1: data[64*counter +: 64] <= main_bus_resp; counter <= counter+1.
  - Beats arrive lowest address first. Gaps (respcyc=0) hold the counter.
  - The beat captured with counter==LINE_BEATS-1 → READY.
- READY:
  - ready=1; abtr_reqcyc=0, bus_busy=0.
  - data is held stable.
  - enable=1 → ARB; ready falls next cycle.
- Ignored inputs:
  - respcyc/resp outside RESP: respack=0, data unchanged.
  - enable outside IDLE/READY: the transfer completes regardless.
  - abtr_grant changes after ARB.
- Latency:
  - enable→abtr_reqcyc: 1 cycle.
  - grant→reqcyc: 1 cycle.
  - Last beat→ready: 1 cycle.
  - Minimum enable→ready: 11 cycles (immediate grant, immediate reqack, contiguous beats).
- A respcyc in the same cycle as reqack is not captured. The first beat is accepted in the cycle after reqack at the earliest.
- Counter wrap: it never exceeds LINE_BEATS; it is reset to 0 on entry to RESP.

Test Plan:
1. reset=0 for 2 cycles with random inputs → every output 0, data all zeros, state IDLE.
2. enable=1, addr=0x0000_0000_1234_5678, grant after 2 cycles, reqack after 3 cycles → abtr_reqcyc=1 from cycle 1; main_bus_req=0x0000_0000_1234_5640 and reqtag=READ/MEMORY held until reqack; reqcyc=0 afterwards.
3. 8 contiguous beats resp=0x1000+i → respack=1 on each beat; data[64i+:64]=0x1000+i; ready=1 exactly one cycle after beat 7; bus_busy=0 and abtr_reqcyc=0 in READY.
4. Same as 3 with respcyc low for 2 cycles between beats 3 and 4, and one respcyc in the reqack cycle → that early pulse is not captured and respack=0 for it; the final line equals scenario 3.
5. reset=0 one cycle after beat 4 → IDLE, data=0, ready=0; a new enable with addr=0x40 completes normally, req=0x40.
6. respcyc pulses while in IDLE → respack=0, data unchanged. enable held high in READY → ARB next cycle, ready=0, a new transaction starts, and the old data stays until overwritten beat by beat.
